// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory path of the core.
//   dmem_state_t     : controller states (IDLE, REQ, DONE, ERR)
//   WORD_ALIGN_MASK  : byte-offset bits that must be zero for a word access
//   DATA_W_DEFAULT   : default data/address width
package mips_pkg;

  localparam int DATA_W_DEFAULT = 32;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Bus-wait counter for the data-memory controller.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears the count)
//   clr      : clear the count (start of a new bus request)
//   en       : count one waited cycle
//   expired  : count has reached TIMEOUT-1, i.e. this is the last allowed wait cycle
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // One extra count of headroom: the counter may step to TIMEOUT on the
  // cycle an ack lands together with expiry, and must not wrap.
  localparam int                CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns a load/store from the control unit into a
// single request/acknowledge transaction on a variable-latency memory bus,
// stalling the core until the access completes, times out or is rejected.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   mem_read, mem_write   : load / store request (store wins if both)
//   addr, wdata           : ALU byte address, store data (rt)
//   rdata                 : load data to the write-back mux
//   stall                 : combinational pipeline freeze
//   bus_err               : one-cycle pulse on timeout or misaligned address
//   bus_req/we/addr/wdata : memory bus request side (registered)
//   bus_ack, bus_rdata    : memory bus response side
module dmem_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  dmem_state_t state, state_nxt;

  logic req_any;
  logic load_req;
  logic misaligned;
  logic accept;
  logic expired;
  logic err_on_load;

  assign req_any    = mem_read | mem_write;
  assign load_req   = mem_read & ~mem_write;
  assign misaligned = |(addr[1:0] & WORD_ALIGN_MASK);
  assign accept     = (state == IDLE) && req_any && !misaligned;

  // Entering ERR on behalf of a load: either a misaligned load from IDLE or
  // a read that ran out of wait cycles.
  assign err_on_load = (state_nxt == ERR) &&
                       (((state == IDLE) && load_req) ||
                        ((state == REQ) && !bus_we));

  dmem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (state == REQ),
    .expired (expired)
  );

  // Next state and the stall output. DONE/ERR deliberately ignore the request
  // inputs: they still belong to the instruction that is retiring.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          stall     = 1'b1;
          state_nxt = misaligned ? ERR : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          state_nxt = DONE;
        end else if (expired) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      stall = 1'b0;
    end
  end

  // bus_req / bus_err are registered from the next state so they line up
  // exactly with the REQ and ERR cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_err   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
    end else begin
      state   <= state_nxt;
      bus_req <= (state_nxt == REQ);
      bus_err <= (state_nxt == ERR);
      if (accept) begin
        bus_we    <= mem_write;
        bus_addr  <= {addr[DATA_W-1:2], 2'b00};
        bus_wdata <= wdata;
      end
      if ((state == REQ) && bus_ack && !bus_we) begin
        rdata <= bus_rdata;
      end
      if (err_on_load) begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic clk;
  logic rst;

  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic        bus_ack   [2];
  logic [31:0] bus_rdata [2];

  wire  [31:0] rdata     [2];
  wire         stall     [2];
  wire         bus_err   [2];
  wire         bus_req   [2];
  wire         bus_we    [2];
  wire  [31:0] bus_addr  [2];
  wire  [31:0] bus_wdata [2];

  int checks = 0;
  int errors = 0;

  // Instance 0 uses the default timeout, instance 1 a short one.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_ctrl #(
      .DATA_W  (32),
      .TIMEOUT ((g == 0) ? 255 : 4)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .rdata     (rdata[g]),
      .stall     (stall[g]),
      .bus_err   (bus_err[g]),
      .bus_req   (bus_req[g]),
      .bus_we    (bus_we[g]),
      .bus_addr  (bus_addr[g]),
      .bus_wdata (bus_wdata[g]),
      .bus_ack   (bus_ack[g]),
      .bus_rdata (bus_rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_of(input int d);
    return (d == 0) ? 255 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is either in flight on the bus (m_busy, m_wait cycles
  // already waited), retiring (m_retire) or erroring (m_err).
  logic        mdl_on = 1'b0;
  logic        m_busy   [2];
  logic        m_retire [2];
  logic        m_err    [2];
  int          m_wait   [2];
  logic        m_we     [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_wdata  [2];
  logic [31:0] m_rdata  [2];

  always @(posedge clk) begin
    if (rst) mdl_on <= 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d]   <= 1'b0;
        m_retire[d] <= 1'b0;
        m_err[d]    <= 1'b0;
        m_wait[d]   <= 0;
        m_we[d]     <= 1'b0;
        m_addr[d]   <= 32'h0;
        m_wdata[d]  <= 32'h0;
        m_rdata[d]  <= 32'h0;
      end else begin
        m_busy[d]   <= 1'b0;
        m_retire[d] <= 1'b0;
        m_err[d]    <= 1'b0;
        if (m_busy[d]) begin
          if (bus_ack[d]) begin
            m_retire[d] <= 1'b1;
            if (!m_we[d]) m_rdata[d] <= bus_rdata[d];
          end else if (m_wait[d] == to_of(d) - 1) begin
            m_err[d] <= 1'b1;
            if (!m_we[d]) m_rdata[d] <= 32'h0;
          end else begin
            m_busy[d] <= 1'b1;
            m_wait[d] <= m_wait[d] + 1;
          end
        end else if (!m_retire[d] && !m_err[d] && (mem_read[d] || mem_write[d])) begin
          if (addr[d][1:0] != 2'b00) begin
            m_err[d] <= 1'b1;
            if (mem_read[d] && !mem_write[d]) m_rdata[d] <= 32'h0;
          end else begin
            m_busy[d]  <= 1'b1;
            m_wait[d]  <= 0;
            m_we[d]    <= mem_write[d];
            m_addr[d]  <= addr[d];
            m_wdata[d] <= wdata[d];
          end
        end
      end
    end
  end

  // Observed statistics, written only by the compare process.
  int   stall_cnt [2] = '{0, 0};
  int   req_cnt   [2] = '{0, 0};
  int   start_cnt [2] = '{0, 0};
  logic req_prev  [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    if (mdl_on) begin
      for (int d = 0; d < 2; d++) begin
        logic exp_stall;
        exp_stall = !rst && (m_busy[d] ||
                    (!m_retire[d] && !m_err[d] && (mem_read[d] || mem_write[d])));
        chk($sformatf("d%0d stall", d),     {31'h0, stall[d]},   {31'h0, exp_stall});
        chk($sformatf("d%0d bus_req", d),   {31'h0, bus_req[d]}, {31'h0, m_busy[d]});
        chk($sformatf("d%0d bus_err", d),   {31'h0, bus_err[d]}, {31'h0, m_err[d]});
        chk($sformatf("d%0d bus_we", d),    {31'h0, bus_we[d]},  {31'h0, m_we[d]});
        chk($sformatf("d%0d bus_addr", d),  bus_addr[d],  m_addr[d]);
        chk($sformatf("d%0d bus_wdata", d), bus_wdata[d], m_wdata[d]);
        chk($sformatf("d%0d rdata", d),     rdata[d],     m_rdata[d]);
        stall_cnt[d] += int'(stall[d]);
        req_cnt[d]   += int'(bus_req[d]);
        if (bus_req[d] && !req_prev[d]) start_cnt[d]++;
        req_prev[d] = bus_req[d];
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one access on instance d in the current cycle (cycle 0). The ack is
  // given in cycle k (k = 0: never). Returns in the first cycle the DUT
  // releases stall, with the request inputs dropped.
  task automatic run(input int d, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int k, input logic [31:0] rdat, output int ncyc);
    logic done;
    done = 1'b0;
    ncyc = 0;
    mem_read[d]  = rd;
    mem_write[d] = wr;
    addr[d]      = a;
    wdata[d]     = wd;
    for (int i = 1; i <= 300 && !done; i++) begin
      cyc();
      if (!stall[d]) begin
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        bus_ack[d]   = 1'b0;
        bus_rdata[d] = 32'h0BAD_0BAD;
        ncyc = i;
        done = 1'b1;
      end else begin
        bus_ack[d]   = (i == k);
        bus_rdata[d] = (i == k) ? rdat : 32'h0BAD_0BAD;
      end
    end
    chk($sformatf("d%0d stall released in budget", d), {31'h0, done}, 32'h1);
  endtask

  int s0, r0, st0, n;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mem_read[d]  = 1'b0;
      mem_write[d] = 1'b0;
      addr[d]      = 32'h0;
      wdata[d]     = 32'h0;
      bus_ack[d]   = 1'b0;
      bus_rdata[d] = 32'h0BAD_0BAD;
    end
    cyc();
    cyc();
    chk("reset bus_req", {31'h0, bus_req[0]}, 32'h0);
    chk("reset rdata",   rdata[0], 32'h0);
    chk("reset stall",   {31'h0, stall[0]}, 32'h0);
    rst = 1'b0;
    cyc();

    // lw 0x10, zero-wait ack
    s0 = stall_cnt[0]; r0 = req_cnt[0];
    run(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, n);
    chk("lw rdata",        rdata[0], 32'hDEAD_BEEF);
    chk("lw bus_addr",     bus_addr[0], 32'h0000_0010);
    chk("lw bus_we",       {31'h0, bus_we[0]}, 32'h0);
    chk("lw bus_err",      {31'h0, bus_err[0]}, 32'h0);
    chk("lw stall cycles", stall_cnt[0] - s0, 32'd2);
    chk("lw req cycles",   req_cnt[0] - r0, 32'd1);
    cyc();

    // sw 0x20, ack after 5 cycles
    s0 = stall_cnt[0]; r0 = req_cnt[0];
    run(0, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 5, 32'h5555_AAAA, n);
    chk("sw bus_we",       {31'h0, bus_we[0]}, 32'h1);
    chk("sw bus_wdata",    bus_wdata[0], 32'h1234_5678);
    chk("sw rdata kept",   rdata[0], 32'hDEAD_BEEF);
    chk("sw stall cycles", stall_cnt[0] - s0, 32'd6);
    chk("sw req cycles",   req_cnt[0] - r0, 32'd5);
    cyc();

    // misaligned lw 0x13
    s0 = stall_cnt[0]; r0 = req_cnt[0];
    run(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, n);
    chk("mis bus_err",      {31'h0, bus_err[0]}, 32'h1);
    chk("mis rdata zero",   rdata[0], 32'h0);
    chk("mis stall cycles", stall_cnt[0] - s0, 32'd1);
    chk("mis req cycles",   req_cnt[0] - r0, 32'd0);
    cyc();
    chk("mis err one cycle", {31'h0, bus_err[0]}, 32'h0);

    // timeout on instance 1 (TIMEOUT=4), after a good load sets rdata
    run(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1, 32'hA5A5_0001, n);
    chk("to pre rdata", rdata[1], 32'hA5A5_0001);
    cyc();
    s0 = stall_cnt[1]; r0 = req_cnt[1];
    run(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 0, 32'h0, n);
    chk("to err cycle",     n, 32'd5);
    chk("to bus_err",       {31'h0, bus_err[1]}, 32'h1);
    chk("to rdata zero",    rdata[1], 32'h0);
    chk("to stall",         {31'h0, stall[1]}, 32'h0);
    chk("to req cycles",    req_cnt[1] - r0, 32'd4);
    chk("to stall cycles",  stall_cnt[1] - s0, 32'd5);
    cyc();
    chk("to back idle err", {31'h0, bus_err[1]}, 32'h0);

    // both requests high: store wins; a following lw held through DONE
    st0 = start_cnt[0]; r0 = req_cnt[0];
    run(0, 1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 2, 32'h9999_9999, n);
    chk("both bus_we",    {31'h0, bus_we[0]}, 32'h1);
    chk("both bus_wdata", bus_wdata[0], 32'hCAFE_F00D);
    chk("both rdata kept", rdata[0], 32'h0);
    mem_read[0] = 1'b1;
    addr[0]     = 32'h0000_0044;
    cyc();
    chk("done ignores lw", {31'h0, bus_req[0]}, 32'h0);
    run(0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h4444_0000, n);
    chk("2nd lw rdata",    rdata[0], 32'h4444_0000);
    chk("2nd lw bus_addr", bus_addr[0], 32'h0000_0044);
    chk("2nd lw bus_we",   {31'h0, bus_we[0]}, 32'h0);
    chk("both req starts", start_cnt[0] - st0, 32'd2);
    chk("both req cycles", req_cnt[0] - r0, 32'd3);
    cyc();

    // reset during REQ, late ack ignored
    mem_read[0] = 1'b1;
    addr[0]     = 32'h0000_0080;
    cyc();
    cyc();
    chk("rst pre bus_req", {31'h0, bus_req[0]}, 32'h1);
    rst = 1'b1;
    mem_read[0] = 1'b0;
    #1;
    chk("rst stall forced", {31'h0, stall[0]}, 32'h0);
    cyc();
    rst = 1'b0;
    chk("rst bus_req",   {31'h0, bus_req[0]}, 32'h0);
    chk("rst rdata",     rdata[0], 32'h0);
    chk("rst bus_addr",  bus_addr[0], 32'h0);
    chk("rst bus_wdata", bus_wdata[0], 32'h0);
    chk("rst bus_we",    {31'h0, bus_we[0]}, 32'h0);
    cyc();
    bus_ack[0]   = 1'b1;
    bus_rdata[0] = 32'h7777_7777;
    cyc();
    bus_ack[0]   = 1'b0;
    bus_rdata[0] = 32'h0BAD_0BAD;
    chk("late ack bus_req", {31'h0, bus_req[0]}, 32'h0);
    chk("late ack rdata",   rdata[0], 32'h0);
    chk("late ack stall",   {31'h0, stall[0]}, 32'h0);
    chk("late ack bus_err", {31'h0, bus_err[0]}, 32'h0);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
